lc3b_mem_model: RTL and testbench
=================================

// Module: lc3b_mem_model
// PURPOSE
//   Parametrised, variable-latency 16-bit memory with a ready handshake.
//   Replaces the tied-off imem_r / fixed-instruction inputs on the LC3BP pipeline.
//   Two instances are used: one for instruction fetch and one for the MEM stage.
//   rdy drives imem_r / !mem_stall, so stall paths are exercised at real latencies.
// PARAMETERS
//   DEPTH_LOG2  10   log2 of word count; word index = req_addr[DEPTH_LOG2:1]
//   LATENCY     4    clock edges from request acceptance to rdy; legal 1..15
//   READ_ONLY   0    1: writes are ignored and flagged on err (instruction memory)
// PORTS
//   clk        in   1   pipeline clock; all state changes on its rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   req_v      in   1   access request; requester holds it and all req_* until rdy
//   req_we     in   1   1 = write, 0 = read
//   req_wmask  in   2   byte enables for writes: [1] = high byte, [0] = low byte
//   req_addr   in   16  byte address
//   req_wdata  in   16  write data
//   rdy        out  1   access complete; high for exactly one cycle
//   rdata      out  16  read data; valid while rdy is high after a read
//   busy       out  1   state != IDLE
//   err        out  1   write attempted while READ_ONLY=1; pulses with rdy
// BEHAVIOUR
// - Reset (async, rst_n=0)
//   - state = IDLE; counter = 0.
//   - rdy = 0, busy = 0, err = 0, rdata = 16'h0000.
//   - Array contents are not reset.
// - FSM states: IDLE, WAIT, DONE. All outputs are registered.
// - IDLE
//   - Edge with req_v=1: latch req_we, req_wmask, req_addr and req_wdata.
//   - Load counter with LATENCY-1 and go to WAIT.
// - WAIT
//   - Edge with req_v=0: abort to IDLE. No write and no rdy.
//   - Else, if counter == 0: go to DONE.
//   - Else: decrement the counter.
// - Entering DONE
//   - rdy = 1.
//   - Read: rdata = mem[latched word index].
//   - Write with READ_ONLY=0: mem updated only in bytes enabled by wmask; rdata unchanged.
//   - Write with READ_ONLY=1: no update; err = 1.
// - DONE
//   - Next edge always returns to IDLE. rdy and err return to 0.
// - Latency
//   - rdy is high in the cycle after edge t0+LATENCY, where t0 is the accepting edge.
//   - Minimum request-to-request spacing is LATENCY+2 edges.
//   - req_v still high in IDLE is accepted as a new request.
// - Latched request
//   - Changes on req_* during WAIT are ignored, except the abort on req_v=0.
// - Address handling
//   - req_addr[0] is ignored; byte selection is done only by wmask.
//   - Address bits above DEPTH_LOG2 are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
// - Mask edge cases
//   - wmask = 2'b00 on a write: completes normally with rdy, no array change.
// - rdata holding
//   - rdata holds its value until the next completed read; it is not cleared by IDLE.
// - Mid-operation reset
//   - Any state goes to IDLE immediately.
//   - A pending write is discarded.
//   - The next access after reset release behaves as a fresh request.
// TESTING
// - Write then read, LATENCY=4:
//   - Write 16'hBEEF to addr 16'h0040, wmask 2'b11 -> rdy exactly 4 edges after acceptance.
//   - Read from 16'h0040 -> rdata 16'hBEEF with rdy, busy high for 5 cycles.
// - Byte writes:
//   - Preload 16'h1234 at addr 16'h0010.
//   - Write wdata 16'hAB00, wmask 2'b10; then wdata 16'h00CD, wmask 2'b01.
//   - Read -> 16'hABCD.
// - Abort:
//   - Write 16'h5555 to 16'h0020, drop req_v after 2 edges -> no rdy, back to IDLE.
//   - Read 16'h0020 -> prior contents unchanged.
// - Boundaries:
//   - LATENCY=1 -> rdy one edge after acceptance.
//   - DEPTH_LOG2=4: write 16'h7777 at addr 16'h0022, read addr 16'h0002 -> 16'h7777 (wrap).
// - READ_ONLY=1:
//   - Write attempt -> rdy and err both high for one cycle, array unchanged.
//   - A following read completes with err=0.
// - Reset mid-WAIT:
//   - Pull rst_n low during a write -> rdy, busy and rdata 0 immediately, write not committed.
//   - After release, a new read completes in LATENCY edges.

Source files
------------

// File: rtl/lc3b_mem_model_if.sv
// ---------------------------------------------------------------------------
// lc3b_mem_model_if
//   Request/response bundle between an LC3BP pipeline stage (master) and a
//   lc3b_mem_model instance (slave). Clock and reset are not part of the
//   bundle; they stay plain ports on the memory model.
//
//   req_v      master->slave  access request, held with all req_* until rdy
//   req_we     master->slave  1 = write, 0 = read
//   req_wmask  master->slave  byte enables: [1] high byte, [0] low byte
//   req_addr   master->slave  byte address (bit 0 ignored)
//   req_wdata  master->slave  write data
//   rdy        slave->master  access complete, one-cycle pulse
//   rdata      slave->master  read data, valid with rdy after a read
//   busy       slave->master  model is not idle
//   err        slave->master  write to a read-only instance, pulses with rdy
// ---------------------------------------------------------------------------
interface lc3b_mem_model_if;
    logic        req_v;
    logic        req_we;
    logic [1:0]  req_wmask;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rdy;
    logic [15:0] rdata;
    logic        busy;
    logic        err;

    modport master (
        output req_v,
        output req_we,
        output req_wmask,
        output req_addr,
        output req_wdata,
        input  rdy,
        input  rdata,
        input  busy,
        input  err
    );

    modport slave (
        input  req_v,
        input  req_we,
        input  req_wmask,
        input  req_addr,
        input  req_wdata,
        output rdy,
        output rdata,
        output busy,
        output err
    );
endinterface

// File: rtl/lc3b_mem_model.sv
// ---------------------------------------------------------------------------
// lc3b_mem_model
//   Variable-latency 16-bit word memory with a ready handshake, used both as
//   the LC3BP instruction memory (READ_ONLY=1) and as the data memory of the
//   MEM stage. rdy feeds imem_r / !mem_stall so the pipeline sees real stalls.
//
//   Parameters
//     DEPTH_LOG2  log2 of the word count; word index = req_addr[DEPTH_LOG2:1]
//     LATENCY     edges from request acceptance to rdy (1..15)
//     READ_ONLY   1: writes leave the array untouched and raise err with rdy
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave side of lc3b_mem_model_if (req_* in; rdy, rdata, busy,
//            err out). All outputs are registered.
// ---------------------------------------------------------------------------
module lc3b_mem_model #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    parameter int READ_ONLY  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    lc3b_mem_model_if.slave   bus
);

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;

    // Request captured at acceptance; later changes on req_* are ignored.
    logic                    we_q;
    logic                    we_nxt;
    logic [1:0]              wmask_q;
    logic [1:0]              wmask_nxt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DEPTH_LOG2-1:0]   idx_nxt;
    logic [15:0]             wdata_q;
    logic [15:0]             wdata_nxt;

    logic                    rdy_q;
    logic                    rdy_nxt;
    logic                    err_q;
    logic                    err_nxt;
    logic                    busy_q;
    logic [15:0]             rdata_q;
    logic [15:0]             rdata_nxt;

    // High on the edge that enters DONE for a committed write.
    logic                    commit;

    logic [15:0]             mem [WORDS];

    // Byte-address bit 0 and bits above the word index never select storage.
    logic                    unused_addr;
    assign unused_addr = ^bus.req_addr;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        wmask_nxt = wmask_q;
        idx_nxt   = idx_q;
        wdata_nxt = wdata_q;
        rdy_nxt   = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = rdata_q;
        commit    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_v) begin
                    we_nxt    = bus.req_we;
                    wmask_nxt = bus.req_wmask;
                    idx_nxt   = bus.req_addr[DEPTH_LOG2:1];
                    wdata_nxt = bus.req_wdata;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                // The abort check wins even on the final wait cycle, so a
                // dropped request never writes and never raises rdy.
                if (!bus.req_v) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    rdy_nxt   = 1'b1;
                    if (!we_q) begin
                        rdata_nxt = mem[idx_q];
                    end else if (READ_ONLY != 0) begin
                        err_nxt = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdy_q   <= rdy_nxt;
            err_q   <= err_nxt;
            busy_q  <= (state_nxt != IDLE);
            rdata_q <= rdata_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Latched request and storage array (not reset). A reset forces state to
    // IDLE asynchronously, which clears commit and drops any pending write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        we_q    <= we_nxt;
        wmask_q <= wmask_nxt;
        idx_q   <= idx_nxt;
        wdata_q <= wdata_nxt;
        if (commit) begin
            if (wmask_q[1]) begin
                mem[idx_q][15:8] <= wdata_q[15:8];
            end
            if (wmask_q[0]) begin
                mem[idx_q][7:0] <= wdata_q[7:0];
            end
        end
    end

    assign bus.rdy   = rdy_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_model.sv
// ---------------------------------------------------------------------------
// tb_lc3b_mem_model
//   Four memory instances with different parameter sets share clk and rst_n:
//     0: DEPTH_LOG2=10 LATENCY=4 READ_ONLY=0
//     1: DEPTH_LOG2=10 LATENCY=1 READ_ONLY=0
//     2: DEPTH_LOG2=4  LATENCY=4 READ_ONLY=0
//     3: DEPTH_LOG2=10 LATENCY=4 READ_ONLY=1
//   Requests are issued one at a time. Each request pushes its expected
//   response onto a scoreboard queue; a monitor pops and compares whenever an
//   instance raises rdy.
// ---------------------------------------------------------------------------
module tb_lc3b_mem_model;

    localparam int NI = 4;
    localparam int LAT [NI] = '{4, 1, 4, 4};
    localparam int DEP [NI] = '{10, 10, 4, 10};
    localparam int RO  [NI] = '{0, 0, 0, 1};

    // mode: 1 = rdata must equal rdata, 2 = rdata must differ from rdata
    typedef struct {
        int          inst;
        int          mode;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        req_v     [NI];
    logic        req_we    [NI];
    logic [1:0]  req_wmask [NI];
    logic [15:0] req_addr  [NI];
    logic [15:0] req_wdata [NI];
    logic        rdy       [NI];
    logic        busy      [NI];
    logic        err       [NI];
    logic [15:0] rdata     [NI];

    logic [15:0] last_rd   [NI];

    exp_t        sb [$];
    exp_t        e_mon;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        lc3b_mem_model_if bus ();

        assign bus.req_v     = req_v[g];
        assign bus.req_we    = req_we[g];
        assign bus.req_wmask = req_wmask[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign rdy[g]        = bus.rdy;
        assign busy[g]       = bus.busy;
        assign err[g]        = bus.err;
        assign rdata[g]      = bus.rdata;

        lc3b_mem_model #(
            .DEPTH_LOG2 (DEP[g]),
            .LATENCY    (LAT[g]),
            .READ_ONLY  (RO[g])
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rdy[i] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: inst %0d got rdy=1, expected no response (t=%0t)", i, $time);
                end else begin
                    e_mon = sb.pop_front();
                    check("resp_inst", 32'(i), 32'(e_mon.inst));
                    if (e_mon.mode == 1) begin
                        check("resp_rdata", 32'(rdata[i]), 32'(e_mon.rdata));
                    end else if (e_mon.mode == 2) begin
                        n_cmp++;
                        if (rdata[i] === e_mon.rdata) begin
                            n_fail++;
                            $display("FAIL ro_unchanged: got %h, required anything but %h", rdata[i], e_mon.rdata);
                        end
                    end
                    check("resp_err", 32'(err[i]), 32'(e_mon.err));
                end
            end
        end
    end

    // Issue one request; called #1 after a rising edge with the instance idle.
    task automatic do_req(input int i, input logic we, input logic [1:0] m,
                          input logic [15:0] a, input logic [15:0] d,
                          input int mode, input logic [15:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        int   nb;
        e = '{i, mode, exp_rd, exp_err};
        sb.push_back(e);
        req_we[i]    = we;
        req_wmask[i] = m;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_v[i]     = 1'b1;
        @(posedge clk);
        #1;
        nb = (busy[i] === 1'b1) ? 1 : 0;
        n  = 0;
        while (rdy[i] !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (busy[i] === 1'b1) nb++;
        end
        check("latency", 32'(n), 32'(LAT[i]));
        check("busy_cycles", 32'(nb), 32'(LAT[i] + 1));
        req_v[i] = 1'b0;
        @(posedge clk);
        #1;
        check("busy_after", 32'(busy[i]), 32'd0);
    endtask

    task automatic wr(input int i, input logic [15:0] a, input logic [15:0] d, input logic [1:0] m);
        do_req(i, 1'b1, m, a, d, 1, last_rd[i], RO[i] != 0);
    endtask

    task automatic rd(input int i, input logic [15:0] a, input logic [15:0] exp);
        do_req(i, 1'b0, 2'b11, a, 16'h0000, 1, exp, 1'b0);
        last_rd[i] = exp;
    endtask

    // Start a write and drop req_v two edges after acceptance.
    task automatic abort_wr(input int i, input logic [15:0] a, input logic [15:0] d);
        req_we[i]    = 1'b1;
        req_wmask[i] = 2'b11;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_v[i]     = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        req_v[i] = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy[i]), 32'd0);
        check("abort_rdy", 32'(rdy[i]), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            req_v[i]     = 1'b0;
            req_we[i]    = 1'b0;
            req_wmask[i] = 2'b00;
            req_addr[i]  = 16'h0000;
            req_wdata[i] = 16'h0000;
            last_rd[i]   = 16'h0000;
        end
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check("reset_rdy", 32'(rdy[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rdata", 32'(rdata[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read
        wr(0, 16'h0040, 16'hBEEF, 2'b11);
        rd(0, 16'h0040, 16'hBEEF);

        // Byte writes
        wr(0, 16'h0010, 16'h1234, 2'b11);
        wr(0, 16'h0010, 16'hAB00, 2'b10);
        wr(0, 16'h0010, 16'h00CD, 2'b01);
        rd(0, 16'h0010, 16'hABCD);

        // Empty mask changes nothing; address bit 0 is ignored
        wr(0, 16'h0010, 16'hFFFF, 2'b00);
        rd(0, 16'h0011, 16'hABCD);

        // rdata holds through idle cycles
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", 32'(rdata[0]), 32'h0000ABCD);

        // Abort leaves prior contents
        wr(0, 16'h0020, 16'h1111, 2'b11);
        abort_wr(0, 16'h0020, 16'h5555);
        rd(0, 16'h0020, 16'h1111);

        // High address bits ignored: 0x0840 aliases 0x0040 with 1024 words
        rd(0, 16'h0840, 16'hBEEF);

        // LATENCY=1
        wr(1, 16'h0008, 16'h4321, 2'b11);
        rd(1, 16'h0008, 16'h4321);

        // DEPTH_LOG2=4 wrap
        wr(2, 16'h0022, 16'h7777, 2'b11);
        rd(2, 16'h0002, 16'h7777);

        // READ_ONLY=1: write flagged, array untouched, following read clean
        wr(3, 16'h0006, 16'hA5A5, 2'b11);
        do_req(3, 1'b0, 2'b11, 16'h0006, 16'h0000, 2, 16'hA5A5, 1'b0);

        // Reset during a pending write
        req_we[0]    = 1'b1;
        req_wmask[0] = 2'b11;
        req_addr[0]  = 16'h0040;
        req_wdata[0] = 16'h9999;
        req_v[0]     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", 32'(rdy[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_rdata", 32'(rdata[0]), 32'd0);
        req_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) last_rd[i] = 16'h0000;
        @(posedge clk);
        #1;
        rd(0, 16'h0040, 16'hBEEF);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
